// File: rtl/bcd_arith_seq.sv
// bcd_arith_seq: multi-cycle BCD add / subtract / multiply unit.
// Operands are DIGITS-digit BCD; the result is 2*DIGITS BCD digits plus a
// sign flag. Flow: capture -> BCD-to-binary -> arithmetic -> double-dabble.
module bcd_arith_seq #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [4*DIGITS-1:0]   a_bcd,
   input  logic [4*DIGITS-1:0]   b_bcd,
   output logic                  busy,
   output logic                  done,
   output logic [8*DIGITS-1:0]   result_bcd,
   output logic                  neg,
   output logic                  err
);

   localparam int BW = 4 * DIGITS;
   localparam int RW = 8 * DIGITS;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      CALC,
      B2B,
      DONE
   } state_t;

   state_t state, state_next;

   // captured request
   logic [BW-1:0] a_sh, b_sh;     // operand digits, shifted up one nibble per CONV cycle
   logic [1:0]    op_q;
   logic          bad_q;          // request rejected; CONV only forwards to DONE

   // binary datapath
   logic [BW-1:0] acc_a, acc_b;   // binary operands
   logic [RW-1:0] mcand;          // multiplicand, shifted left each mul step
   logic [BW-1:0] mplier;         // multiplier, shifted right each mul step
   logic [RW-1:0] bin;            // arithmetic result, then shifted out MSB-first
   logic [RW-1:0] bcd;            // double-dabble accumulator
   logic          sgn;            // pending sign of a subtract
   logic [5:0]    cnt;            // cycle counter within a phase

   logic [BW-1:0] conv_a, conv_b;
   logic [RW-1:0] bcd_adj, bcd_next;
   logic          in_ok;
   logic          conv_last, calc_last, b2b_last;

   function automatic logic digits_ok(input logic [BW-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   assign in_ok = digits_ok(a_bcd) && digits_ok(b_bcd) && (op != 2'b11);

   assign conv_a = acc_a * BW'(10) + BW'(a_sh[BW-1 -: 4]);
   assign conv_b = acc_b * BW'(10) + BW'(b_sh[BW-1 -: 4]);

   assign conv_last = (cnt == 6'(DIGITS - 1));
   assign calc_last = (op_q != OP_MUL) || (cnt == 6'(BW - 1));
   assign b2b_last  = (cnt == 6'(RW - 1));

   // double-dabble correction: every nibble >= 5 gets +3 before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 2 * DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   assign bcd_next = {bcd_adj[RW-2:0], bin[RW-1]};

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // next-state and handshake outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = CONV;
         end
         CONV: begin
            busy = !bad_q;
            if (bad_q)          state_next = DONE;
            else if (conv_last) state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (calc_last) state_next = B2B;
         end
         B2B: begin
            busy = 1'b1;
            if (b2b_last) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // datapath and registered result outputs
   // A rejected request still passes through one CONV cycle (with busy low)
   // so that its done pulse lands one edge after acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh       <= '0;
         b_sh       <= '0;
         op_q       <= '0;
         bad_q      <= 1'b0;
         acc_a      <= '0;
         acc_b      <= '0;
         mcand      <= '0;
         mplier     <= '0;
         bin        <= '0;
         bcd        <= '0;
         sgn        <= 1'b0;
         cnt        <= '0;
         result_bcd <= '0;
         neg        <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a_bcd;
                  b_sh  <= b_bcd;
                  op_q  <= op;
                  bad_q <= !in_ok;
                  acc_a <= '0;
                  acc_b <= '0;
                  sgn   <= 1'b0;
                  cnt   <= '0;
                  if (in_ok) err <= 1'b0;
               end
            end
            CONV: begin
               if (bad_q) begin
                  err        <= 1'b1;
                  neg        <= 1'b0;
                  result_bcd <= '0;
               end else begin
                  acc_a <= conv_a;
                  acc_b <= conv_b;
                  a_sh  <= a_sh << 4;
                  b_sh  <= b_sh << 4;
                  if (conv_last) begin
                     cnt    <= '0;
                     bin    <= '0;
                     mcand  <= RW'(conv_a);
                     mplier <= conv_b;
                  end else begin
                     cnt <= cnt + 6'd1;
                  end
               end
            end
            CALC: begin
               case (op_q)
                  OP_ADD: bin <= RW'(acc_a) + RW'(acc_b);
                  OP_SUB: begin
                     if (acc_a >= acc_b) begin
                        bin <= RW'(acc_a - acc_b);
                        sgn <= 1'b0;
                     end else begin
                        bin <= RW'(acc_b - acc_a);
                        sgn <= 1'b1;
                     end
                  end
                  default: begin
                     bin    <= bin + (mplier[0] ? mcand : '0);
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               endcase
               if (calc_last) begin
                  cnt <= '0;
                  bcd <= '0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            B2B: begin
               bcd <= bcd_next;
               bin <= bin << 1;
               cnt <= cnt + 6'd1;
               if (b2b_last) begin
                  result_bcd <= bcd_next;
                  neg        <= sgn;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_arith_seq.sv
// Testbench for bcd_arith_seq: a cycle-level reference model of the
// handshake and decimal arithmetic, checked every cycle, plus directed
// vectors with literal expectations (including a DIGITS=4 instance).
module tb_bcd_arith_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start4;
   logic [1:0]  op, op4;
   logic [7:0]  a_in, b_in;
   logic [15:0] a4, b4;
   logic        busy, done, neg, err;
   logic [15:0] result_bcd;
   logic        busy4, done4, neg4, err4;
   logic [31:0] result4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_arith_seq #(.DIGITS(2)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a_bcd(a_in), .b_bcd(b_in), .busy(busy), .done(done),
      .result_bcd(result_bcd), .neg(neg), .err(err)
   );

   bcd_arith_seq #(.DIGITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .op(op4),
      .a_bcd(a4), .b_bcd(b4), .busy(busy4), .done(done4),
      .result_bcd(result4), .neg(neg4), .err(err4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // ---------------- reference model (2-digit instance) ----------------
   function automatic int from_bcd(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic is_valid(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      return (o != 2'b11) && (a[7:4] <= 4'd9) && (a[3:0] <= 4'd9) &&
             (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
   endfunction

   // {neg, result} of the decimal operation
   function automatic logic [16:0] model_result(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = from_bcd(a);
      y = from_bcd(b);
      case (o)
         2'b00:   return {1'b0, to_bcd(x + y)};
         2'b01:   return (x >= y) ? {1'b0, to_bcd(x - y)} : {1'b1, to_bcd(y - x)};
         default: return {1'b0, to_bcd(x * y)};
      endcase
   endfunction

   // edges from acceptance to done: digits + calc cycles + result bits
   function automatic int latency(input logic [1:0] o);
      return 2 + ((o == 2'b10) ? 8 : 1) + 16;
   endfunction

   int          m_timer;
   logic        m_done, m_neg, m_err, p_neg, p_err;
   logic [15:0] m_res, p_res;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_timer <= 0;
         m_done  <= 1'b0;
         m_res   <= '0;
         m_neg   <= 1'b0;
         m_err   <= 1'b0;
         p_res   <= '0;
         p_neg   <= 1'b0;
         p_err   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_timer != 0) begin
            m_timer <= m_timer - 1;
            if (m_timer == 1) begin
               m_done <= 1'b1;
               m_res  <= p_res;
               m_neg  <= p_neg;
               m_err  <= p_err;
            end
         end else if (!m_done && start) begin
            if (!is_valid(op, a_in, b_in)) begin
               m_timer <= 1;
               p_err   <= 1'b1;
               p_res   <= '0;
               p_neg   <= 1'b0;
            end else begin
               m_timer        <= latency(op);
               p_err          <= 1'b0;
               m_err          <= 1'b0;
               {p_neg, p_res} <= model_result(op, a_in, b_in);
            end
         end
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      logic [19:0] act, expv;
      act  = {busy, done, neg, err, result_bcd};
      expv = {(m_timer != 0) && !p_err, m_done, m_neg, m_err, m_res};
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL cycle busy/done/neg/err/result: got %h expected %h at %0t", act, expv, $time);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_op(input string nm, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] er, input logic en, input logic ee, input int elat);
      int   k;
      logic got;
      @(negedge clk);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0; got = 1'b0;
      while (!got && k < 100) begin
         @(posedge clk); #1;
         k++;
         if (done) got = 1'b1;
      end
      chk({nm, "_latency"}, k, elat);
      chk({nm, "_result"}, result_bcd, er);
      chk({nm, "_neg"}, neg, en);
      chk({nm, "_err"}, err, ee);
      @(posedge clk); #1;
      chk({nm, "_done_low"}, done, 1'b0);
   endtask

   initial begin
      int k, ndone, done_at, d1, d2;
      logic got;
      reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
      start4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {busy, done, neg, err, result_bcd}, 20'h0);
      @(negedge clk) reset = 1'b0;

      do_op("add_47_38", 2'b00, 8'h47, 8'h38, 16'h0085, 1'b0, 1'b0, 19);
      do_op("add_99_99", 2'b00, 8'h99, 8'h99, 16'h0198, 1'b0, 1'b0, 19);
      do_op("sub_23_57", 2'b01, 8'h23, 8'h57, 16'h0034, 1'b1, 1'b0, 19);
      do_op("sub_42_42", 2'b01, 8'h42, 8'h42, 16'h0000, 1'b0, 1'b0, 19);
      do_op("sub_90_07", 2'b01, 8'h90, 8'h07, 16'h0083, 1'b0, 1'b0, 19);
      do_op("mul_99_99", 2'b10, 8'h99, 8'h99, 16'h9801, 1'b0, 1'b0, 26);
      do_op("mul_00_57", 2'b10, 8'h00, 8'h57, 16'h0000, 1'b0, 1'b0, 26);
      do_op("mul_12_34", 2'b10, 8'h12, 8'h34, 16'h0408, 1'b0, 1'b0, 26);
      do_op("rej_digit", 2'b00, 8'h3A, 8'h11, 16'h0000, 1'b0, 1'b1, 1);
      do_op("rej_op",    2'b11, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 1);
      do_op("add_clr",   2'b00, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 19);

      // restart request and operand changes during a multiply are ignored
      @(negedge clk);
      start = 1'b1; op = 2'b10; a_in = 8'h99; b_in = 8'h99;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; done_at = 0;
      for (k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            done_at = k;
            chk("midop_result", result_bcd, 16'h9801);
         end
         if (k == 4) start = 1'b1;
         if (k == 5) begin
            start = 1'b0; a_in = 8'h12; b_in = 8'h34;
         end
      end
      chk("midop_done_count", ndone, 1);
      chk("midop_done_edge", done_at, 26);

      // reset at edge 10 of a multiply aborts it
      @(negedge clk);
      start = 1'b1; op = 2'b10; a_in = 8'h57; b_in = 8'h68;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_outputs", {busy, done, neg, err, result_bcd}, 20'h0);
      @(negedge clk) reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      do_op("add_after_abort", 2'b00, 8'h05, 8'h05, 16'h0010, 1'b0, 1'b0, 19);

      // start held high relaunches one cycle after each DONE
      @(negedge clk);
      start = 1'b1; op = 2'b00; a_in = 8'h12; b_in = 8'h34;
      d1 = -1; d2 = -1;
      for (k = 0; k < 45; k++) begin
         @(posedge clk); #1;
         if (done) begin
            if (d1 < 0) d1 = k;
            else        d2 = k;
         end
      end
      start = 1'b0;
      chk("held_first_done", d1, 19);
      chk("held_second_done", d2, 40);
      repeat (30) @(posedge clk);

      // four-digit multiply on the second instance
      @(negedge clk);
      start4 = 1'b1; op4 = 2'b10; a4 = 16'h9999; b4 = 16'h9999;
      @(posedge clk); #1;
      start4 = 1'b0;
      k = 0; got = 1'b0;
      while (!got && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (done4) got = 1'b1;
      end
      chk("d4_latency", k, 52);
      chk("d4_result", result4, 32'h99980001);
      chk("d4_neg_err", {neg4, err4}, 2'b00);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
